// File: rtl/imem_prog.sv
// Run-time loadable instruction memory: byte-stream programming port plus registered fetch port.
// Optional macro IMEM_BOUNDS_CHECK_EN returns NOP_WORD for fetches beyond DEPTH or the loaded image.
module imem_prog #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int DEPTH      = 1024,
  parameter logic [DATA_WIDTH-1:0] NOP_WORD = 32'h5000_0000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic                  fetch_en,
  output logic [DATA_WIDTH-1:0] InstructionOut,
  output logic                  instr_valid,
  input  logic                  prog_start,
  input  logic [7:0]            prog_byte,
  input  logic                  prog_valid,
  input  logic                  prog_last,
  output logic                  prog_ready,
  output logic                  prog_busy,
  output logic                  prog_done,
  output logic                  prog_error,
  output logic [ADDR_WIDTH:0]   word_count
);

  localparam int BPW   = DATA_WIDTH / 8;
  localparam int IDX_W = (BPW > 1) ? $clog2(BPW) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_CLEAR, ST_LOAD, ST_DONE} state_t;

  state_t                  state_r, state_s;
  logic [DATA_WIDTH-1:0]   mem_r [DEPTH];
  logic [ADDR_WIDTH-1:0]   clr_ptr_r;
  logic [IDX_W-1:0]        byte_idx_r;
  logic [DATA_WIDTH-1:0]   asm_r;
  logic [ADDR_WIDTH:0]     word_count_r;
  logic                    prog_error_r, prog_busy_r, prog_ready_r, prog_done_r;
  logic [DATA_WIDTH-1:0]   instr_r;
  logic                    instr_valid_r;

  logic                    accept_s, full_s, word_end_s, we_s;
  logic [ADDR_WIDTH-1:0]   wa_s;
  logic [DATA_WIDTH-1:0]   wd_s, merged_s, rd_s;

  assign accept_s   = (state_r == ST_LOAD) && prog_valid;
  assign full_s     = (word_count_r == (ADDR_WIDTH+1)'(DEPTH));
  assign word_end_s = accept_s && ((byte_idx_r == IDX_W'(BPW-1)) || prog_last);
  // First byte of a word lands in the top lane; unfilled low lanes stay zero.
  assign merged_s   = asm_r | ((DATA_WIDTH'(prog_byte) << (DATA_WIDTH-8)) >> {byte_idx_r, 3'b000});

  // Next-state and memory write-port selection.
  always_comb begin
    state_s = state_r;
    we_s    = 1'b0;
    wa_s    = clr_ptr_r;
    wd_s    = NOP_WORD;
    case (state_r)
      ST_IDLE: begin
        if (prog_start) state_s = ST_CLEAR;
        else            state_s = ST_IDLE;
      end
      ST_CLEAR: begin
        we_s = 1'b1;
        if (clr_ptr_r == ADDR_WIDTH'(DEPTH-1)) state_s = ST_LOAD;
        else                                    state_s = ST_CLEAR;
      end
      ST_LOAD: begin
        we_s = word_end_s && !full_s;
        wa_s = word_count_r[ADDR_WIDTH-1:0];
        wd_s = merged_s;
        if (accept_s && prog_last) state_s = ST_DONE;
        else                       state_s = ST_LOAD;
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // Memory array write port; contents are deliberately never reset.
  always_ff @(posedge clock) begin
    if (we_s) mem_r[wa_s] <= wd_s;
  end

  // FSM state, load bookkeeping and programming-side status outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      clr_ptr_r    <= '0;
      byte_idx_r   <= '0;
      asm_r        <= '0;
      word_count_r <= '0;
      prog_error_r <= 1'b0;
      prog_busy_r  <= 1'b0;
      prog_ready_r <= 1'b0;
      prog_done_r  <= 1'b0;
    end else begin
      state_r      <= state_s;
      prog_busy_r  <= (state_s == ST_CLEAR) || (state_s == ST_LOAD);
      prog_ready_r <= (state_s == ST_LOAD);
      prog_done_r  <= (state_s == ST_DONE);
      if ((state_r == ST_IDLE) && prog_start) begin
        clr_ptr_r    <= '0;
        byte_idx_r   <= '0;
        asm_r        <= '0;
        word_count_r <= '0;
        prog_error_r <= 1'b0;
      end else begin
        if (state_r == ST_CLEAR) clr_ptr_r <= clr_ptr_r + ADDR_WIDTH'(1);
        if (accept_s) begin
          if (word_end_s) begin
            byte_idx_r <= '0;
            asm_r      <= '0;
            if (!full_s) word_count_r <= word_count_r + (ADDR_WIDTH+1)'(1);
          end else begin
            byte_idx_r <= byte_idx_r + IDX_W'(1);
            asm_r      <= merged_s;
          end
          // Bytes arriving once the array is full are accepted but dropped.
          if (full_s) prog_error_r <= 1'b1;
        end
      end
    end
  end

`ifdef IMEM_BOUNDS_CHECK_EN
  logic loaded_r;

  // Remembers that the current word_count describes a finished image.
  always_ff @(posedge clock) begin
    if (reset)                                 loaded_r <= 1'b0;
    else if ((state_r == ST_IDLE) && prog_start) loaded_r <= 1'b0;
    else if (state_r == ST_DONE)                loaded_r <= 1'b1;
  end

  // Out-of-image fetches read back as NOP_WORD.
  always_comb begin
    rd_s = mem_r[address];
    if (({1'b0, address} >= (ADDR_WIDTH+1)'(DEPTH)) ||
        (loaded_r && ({1'b0, address} >= word_count_r))) begin
      rd_s = NOP_WORD;
    end else begin
      rd_s = mem_r[address];
    end
  end
`else
  assign rd_s = mem_r[address];
`endif

  // Registered fetch port; nops are fed to the core while memory is being rewritten.
  always_ff @(posedge clock) begin
    if (reset) begin
      instr_r       <= NOP_WORD;
      instr_valid_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (fetch_en) begin
            instr_r       <= rd_s;
            instr_valid_r <= 1'b1;
          end else begin
            instr_valid_r <= 1'b0;
          end
        end
        default: begin
          instr_r       <= NOP_WORD;
          instr_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign InstructionOut = instr_r;
  assign instr_valid    = instr_valid_r;
  assign prog_ready     = prog_ready_r;
  assign prog_busy      = prog_busy_r;
  assign prog_done      = prog_done_r;
  assign prog_error     = prog_error_r;
  assign word_count     = word_count_r;

endmodule

// File: tb/tb_imem_prog.sv
// Self-checking bench for imem_prog (DEPTH=16): directed loads plus randomized images
// compared against a byte-list-to-word-image reference model.
module tb_imem_prog;
  localparam int AW = 4;
  localparam int DP = 16;
  localparam int DW = 32;
  localparam logic [31:0] NOP = 32'h5000_0000;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [AW-1:0] address = '0;
  logic          fetch_en = 1'b0;
  logic [DW-1:0] InstructionOut;
  logic          instr_valid;
  logic          prog_start = 1'b0;
  logic [7:0]    prog_byte = 8'h00;
  logic          prog_valid = 1'b0;
  logic          prog_last = 1'b0;
  logic          prog_ready, prog_busy, prog_done, prog_error;
  logic [AW:0]   word_count;

  imem_prog #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DP), .NOP_WORD(NOP)) dut (
    .clock(clock), .reset(reset), .address(address), .fetch_en(fetch_en),
    .InstructionOut(InstructionOut), .instr_valid(instr_valid),
    .prog_start(prog_start), .prog_byte(prog_byte), .prog_valid(prog_valid),
    .prog_last(prog_last), .prog_ready(prog_ready), .prog_busy(prog_busy),
    .prog_done(prog_done), .prog_error(prog_error), .word_count(word_count)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] ref_mem [DP];
  int          ref_wc = 0;
  bit          ref_err = 1'b0;
  bit          ref_loaded = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Reference: cleared array overlaid with the byte list packed MSB-first, 4 bytes per word.
  task automatic model_load(input logic [7:0] b[$]);
    int nw;
    logic [31:0] w;
    nw = (b.size() + 3) / 4;
    for (int i = 0; i < DP; i++) ref_mem[i] = NOP;
    for (int i = 0; i < nw && i < DP; i++) begin
      w = 32'h0;
      for (int k = 0; k < 4; k++)
        if (4*i + k < b.size()) w = w | (32'(b[4*i+k]) << (24 - 8*k));
      ref_mem[i] = w;
    end
    ref_wc     = (nw > DP) ? DP : nw;
    ref_err    = (b.size() > 4*DP);
    ref_loaded = 1'b1;
  endtask

  task automatic wait_clear();
    int cnt;
    prog_start = 1'b1;
    step();
    prog_start = 1'b0;
    chk("busy_after_start", 32'(prog_busy), 32'd1);
    chk("ready_in_clear", 32'(prog_ready), 32'd0);
    cnt = 0;
    while (prog_ready !== 1'b1 && cnt < 200) begin
      step();
      cnt++;
    end
    chk("clear_cycles", 32'(cnt), 32'(DP));
  endtask

  task automatic run_load(input logic [7:0] b[$], input int gap_pct);
    wait_clear();
    for (int i = 0; i < b.size(); i++) begin
      while (32'(gap_pct) > $urandom_range(99)) begin
        prog_valid = 1'b0;
        fetch_en   = 1'($urandom);
        address    = AW'($urandom);
        step();
        chk("ready_in_load", 32'(prog_ready), 32'd1);
        chk("load_fetch_valid", 32'(instr_valid), 32'd0);
      end
      prog_valid = 1'b1;
      prog_byte  = b[i];
      prog_last  = (i == b.size() - 1);
      prog_start = 1'($urandom);
      fetch_en   = 1'($urandom);
      address    = AW'($urandom);
      step();
      chk("load_fetch_nop", InstructionOut, NOP);
      chk("load_fetch_valid", 32'(instr_valid), 32'd0);
      if (i != b.size() - 1) chk("busy_mid_load", 32'(prog_busy), 32'd1);
    end
    prog_valid = 1'b0;
    prog_last  = 1'b0;
    prog_start = 1'b0;
    fetch_en   = 1'b0;
    model_load(b);
    chk("done_pulse", 32'(prog_done), 32'd1);
    chk("busy_fall", 32'(prog_busy), 32'd0);
    chk("ready_fall", 32'(prog_ready), 32'd0);
    chk("word_count", 32'(word_count), 32'(ref_wc));
    chk("prog_error", 32'(prog_error), 32'(ref_err));
    step();
    chk("done_one_cycle", 32'(prog_done), 32'd0);
    chk("error_sticky", 32'(prog_error), 32'(ref_err));
  endtask

  task automatic fetch_chk(input int a);
    logic [31:0] exp;
    exp = ref_mem[a];
`ifdef IMEM_BOUNDS_CHECK_EN
    if (ref_loaded && a >= ref_wc) exp = NOP;
`endif
    address  = AW'(a);
    fetch_en = 1'b1;
    step();
    chk("fetch_data", InstructionOut, exp);
    chk("fetch_valid", 32'(instr_valid), 32'd1);
    fetch_en = 1'b0;
    address  = AW'($urandom);
    step();
    chk("fetch_hold", InstructionOut, exp);
    chk("fetch_idle_valid", 32'(instr_valid), 32'd0);
  endtask

  initial begin
    logic [7:0] q[$];

    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    chk("rst_instr", InstructionOut, NOP);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_ready", 32'(prog_ready), 32'd0);
    chk("rst_busy", 32'(prog_busy), 32'd0);
    chk("rst_done", 32'(prog_done), 32'd0);
    chk("rst_error", 32'(prog_error), 32'd0);
    chk("rst_wc", 32'(word_count), 32'd0);

    q = '{8'h34, 8'h00, 8'h00, 8'h01, 8'h5C, 8'h00, 8'h00, 8'h00};
    run_load(q, 0);
    fetch_chk(0);
    fetch_chk(1);
    fetch_chk(5);

    q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
    run_load(q, 0);
    fetch_chk(0);
    fetch_chk(1);
    fetch_chk(2);

    q = {};
    for (int i = 0; i < 70; i++) q.push_back(8'($urandom));
    run_load(q, 0);
    fetch_chk(0);
    fetch_chk(15);

    wait_clear();
    for (int i = 0; i < 2; i++) begin
      prog_valid = 1'b1;
      prog_byte  = 8'($urandom);
      step();
    end
    prog_valid = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("midrst_busy", 32'(prog_busy), 32'd0);
    chk("midrst_ready", 32'(prog_ready), 32'd0);
    chk("midrst_wc", 32'(word_count), 32'd0);
    chk("midrst_error", 32'(prog_error), 32'd0);
    chk("midrst_instr", InstructionOut, NOP);
    chk("midrst_valid", 32'(instr_valid), 32'd0);
    ref_loaded = 1'b0;

    q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    run_load(q, 0);
    fetch_chk(3);
    fetch_chk(1);

    for (int t = 0; t < 5; t++) begin
      q = {};
      for (int i = 0; i < $urandom_range(72, 1); i++) q.push_back(8'($urandom));
      run_load(q, 30);
      for (int a = 0; a < DP; a++) fetch_chk(a);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/imem_prog.md
# imem_prog

Parametrised, run-time loadable instruction memory for the processor fetch stage. It replaces a fixed instruction table with a synchronous RAM: a byte-stream programming port fills it after reset, and the fetch port gives registered, validity-flagged instruction reads. It sits between the PC register and the decoder. The programming side is fed by the board-level loader (switches or UART byte source).

## Interface
Parameters:
- DATA_WIDTH, 32, instruction width in bits; must be a multiple of 8.
- ADDR_WIDTH, 10, fetch/write address width.
- DEPTH, 1024, number of words; DEPTH ≤ 2^ADDR_WIDTH.
- NOP_WORD, 32'h5000_0000, fill and substitute word (opcode 010100).

Ports:
- clock  in  1  single clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- address  in  ADDR_WIDTH  fetch address (PC).
- fetch_en  in  1  fetch request for `address` this cycle.
- InstructionOut  out  DATA_WIDTH  registered fetched word.
- instr_valid  out  1  InstructionOut holds a fetched word from memory.
- prog_start  in  1  one-cycle pulse that begins a program load.
- prog_byte  in  8  program byte, MSB-first within each word.
- prog_valid  in  1  prog_byte valid.
- prog_last  in  1  qualifies the final byte of the image.
- prog_ready  out  1  block accepts a byte this cycle.
- prog_busy  out  1  high in CLEAR and LOAD.
- prog_done  out  1  one-cycle pulse when the load completes.
- prog_error  out  1  sticky; set when the image overflows DEPTH. Cleared by prog_start or reset.
- word_count  out  ADDR_WIDTH+1  words written by the last or current load.

## Operation
- The FSM has four states: IDLE, CLEAR, LOAD and DONE. Reset puts it in IDLE.
- IDLE + prog_start → CLEAR.
  - On entry, the clear pointer, word_count, byte index and prog_error are zeroed.
- CLEAR writes NOP_WORD to address 0…DEPTH-1, one word per cycle.
  - After address DEPTH-1 is written → LOAD.
- LOAD: prog_ready=1. A byte is accepted when prog_valid && prog_ready.
  - Bytes shift into an assembly register, first byte → bits [DATA_WIDTH-1:DATA_WIDTH-8].
  - When byte DATA_WIDTH/8 of a word is accepted, the word is written at word_count on that same edge, and word_count increments.
  - If prog_last is accepted mid-word, the missing low bytes are zero and the partial word is written at once.
  - Any accepted prog_last → DONE.
- Overflow: if word_count==DEPTH, further bytes are still accepted but discarded; prog_error is set. word_count saturates at DEPTH.
- DONE: prog_done=1 for one cycle, then → IDLE.
- prog_start in CLEAR, LOAD or DONE is ignored.
- Fetch in IDLE or DONE: fetch_en=1 registers mem[address] into InstructionOut and sets instr_valid=1 in the next cycle. fetch_en=0 holds InstructionOut and clears instr_valid.
- Fetch in CLEAR or LOAD: the request is ignored. InstructionOut is loaded with NOP_WORD and instr_valid=0, so the core executes nops while memory is rewritten.
- Reset mid-load: FSM → IDLE and outputs return to reset values. Memory contents are not cleared and are undefined for the unfinished region.
- Memory contents are never reset.

## Timing
- Reset values of outputs:
  - InstructionOut=NOP_WORD; instr_valid=0.
  - prog_ready=0; prog_busy=0; prog_done=0; prog_error=0.
  - word_count=0.
- Fetch latency: 1 cycle (address at edge N → data after edge N+1).
- The fetch port and the write port are never active in the same cycle, so there are no read/write collisions.
- CLEAR takes exactly DEPTH cycles. prog_busy rises the cycle after the prog_start edge.
- LOAD sustains one byte per cycle, so a full word takes DATA_WIDTH/8 cycles.
- prog_done asserts the cycle after the last byte is accepted. prog_busy falls in that same cycle.

## Configuration
- Macro IMEM_BOUNDS_CHECK_EN.
- Defined: a fetch with address ≥ DEPTH, or ≥ word_count after a completed load, returns NOP_WORD with instr_valid=1.
- Undefined: no bounds check. The address is used modulo the physical array, with wrap-around when DEPTH=2^ADDR_WIDTH; otherwise the read data is undefined.

## Test plan
- Reset → InstructionOut=32'h5000_0000, instr_valid=0, prog_ready=0, word_count=0.
- DEPTH=16, prog_start, then stream 8 bytes 34 00 00 01 5C 00 00 00 (prog_last on the 8th):
  - 16 CLEAR cycles, then word_count=2, prog_done pulses once.
  - Fetches at 0/1 return 32'h3400_0001/32'h5C00_0000.
  - Fetch at 5 returns 32'h5000_0000.
- Stream 5 bytes AA BB CC DD EE with prog_last on EE → word 1 = 32'hEE00_0000, word_count=2.
- DEPTH=4 with 20 bytes → prog_error=1, word_count=4; all bytes are accepted without stall and prog_done pulses.
- Fetch during LOAD → instr_valid=0, InstructionOut=NOP. Assert reset after 2 bytes → IDLE, prog_busy=0 next cycle.
- With IMEM_BOUNDS_CHECK_EN after a 2-word load, fetch address 3 → 32'h5000_0000; without it, the stale cleared word is returned.
